instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_if.sv | 10 +
 rtl/instruction_fetch.sv | 134 +++++++++++++
 tb/tb_instruction_fetch.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
interface instruction_fetch_if;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  modport master (output o_mem_req, output o_mem_addr, input i_mem_ack, input i_mem_rdata);
  modport slave  (input o_mem_req, input o_mem_addr, output i_mem_ack, output i_mem_rdata);
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch FSM (IDLE/REQ/HOLD) with PC, branch redirect and IR handshake.
// Optional fetch-timeout watchdog is built when IFETCH_TIMEOUT_EN is defined.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 15
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_run,
  input  logic                        i_pc_ld,
  input  logic [31:0]                 i_pc_target,
  instruction_fetch_if.master         mem,
  output logic [31:0]                 o_instruction,
  output logic                        o_il,
  input  logic                        i_ir_ready,
  output logic [31:0]                 o_pc,
  output logic                        o_busy,
  output logic                        o_fault
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;

  state_e      state_q;
  logic [31:0] pc_q, redir_pc_q, addr_q, instr_q, opc_q;
  logic        redir_q, req_q, il_q, busy_q;
  logic [31:0] pc_d, redir_tgt_d;
  logic        ack_ok, timeout_hit;

  assign pc_d        = i_pc_ld ? i_pc_target : pc_q;
  assign redir_tgt_d = i_pc_ld ? i_pc_target : redir_pc_q;
  // Acks are only meaningful while a request is actually on the bus
  assign ack_ok      = (state_q == REQ) && req_q && mem.i_mem_ack;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wait_q;
  logic          fault_q;

  assign timeout_hit = (state_q == REQ) && req_q && !mem.i_mem_ack &&
                       (wait_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state_q != REQ || !req_q || mem.i_mem_ack || timeout_hit) wait_q <= '0;
      else                                                          wait_q <= wait_q + 1'b1;
      if (timeout_hit) fault_q <= 1'b1;
    end
  end
  assign o_fault = fault_q;
`else
  assign timeout_hit = 1'b0;
  assign o_fault     = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      redir_pc_q <= '0;
      redir_q    <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      instr_q    <= '0;
      opc_q      <= '0;
      il_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      il_q <= 1'b0;
      case (state_q)
        IDLE: begin
          pc_q <= pc_d;
          if (i_run) begin
            state_q <= REQ;
            busy_q  <= 1'b1;
            req_q   <= 1'b1;
            addr_q  <= pc_d;
          end
        end
        REQ: begin
          if (i_pc_ld) begin
            redir_q    <= 1'b1;
            redir_pc_q <= i_pc_target;
          end
          if (ack_ok) begin
            if (redir_q || i_pc_ld) begin
              // Drop the in-flight word and reissue straight at the target
              pc_q    <= redir_tgt_d;
              addr_q  <= redir_tgt_d;
              redir_q <= 1'b0;
            end else begin
              instr_q <= mem.i_mem_rdata;
              opc_q   <= pc_q;
              pc_q    <= pc_q + 32'd1;
              il_q    <= 1'b1;
              req_q   <= 1'b0;
              state_q <= HOLD;
            end
          end else if (timeout_hit) begin
            req_q <= 1'b0;
          end else if (!req_q) begin
            req_q <= 1'b1;
          end
        end
        HOLD: begin
          pc_q <= pc_d;
          if (i_ir_ready) begin
            if (i_run) begin
              state_q <= REQ;
              req_q   <= 1'b1;
              addr_q  <= pc_d;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem.o_mem_req  = req_q;
  assign mem.o_mem_addr = addr_q;
  assign o_instruction  = instr_q;
  assign o_pc           = opc_q;
  assign o_il           = il_q;
  assign o_busy         = busy_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: fetch, IR stall, redirects, PC wrap, timeout, reset.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        run = 1'b0, pc_ld = 1'b0, ir_ready = 1'b0;
  logic [31:0] pc_target = '0;
  logic [31:0] instruction, opc;
  logic        il, busy, fault;
  int          checks = 0, errors = 0;

  instruction_fetch_if mem_if();

  instruction_fetch dut (
    .i_clk(clk), .i_rstn(rstn), .i_run(run), .i_pc_ld(pc_ld), .i_pc_target(pc_target),
    .mem(mem_if), .o_instruction(instruction), .o_il(il), .i_ir_ready(ir_ready),
    .o_pc(opc), .o_busy(busy), .o_fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ack the current request, check the presented word, then release it via i_ir_ready
  task automatic fetch(input logic [31:0] data, input logic [31:0] exp_pc);
    mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = data;
    tick();
    mem_if.i_mem_ack = 1'b0;
    check("fetch_il", {31'd0, il}, 32'd1);
    check("fetch_instr", instruction, data);
    check("fetch_pc", opc, exp_pc);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
  endtask

  initial begin
    mem_if.i_mem_ack = 1'b0;
    mem_if.i_mem_rdata = '0;
    #2 rstn = 1'b0;
    #1;
    check("rst_req", {31'd0, mem_if.o_mem_req}, 32'd0);
    check("rst_addr", mem_if.o_mem_addr, 32'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_pc", opc, 32'd0);
    check("rst_il", {31'd0, il}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // Basic fetch, ack two cycles after request
    run = 1'b1;
    tick();
    check("req_rise", {31'd0, mem_if.o_mem_req}, 32'd1);
    check("req_addr0", mem_if.o_mem_addr, 32'd0);
    check("busy_req", {31'd0, busy}, 32'd1);
    tick();
    check("req_stable", {31'd0, mem_if.o_mem_req}, 32'd1);
    mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 32'h8003_0123;
    tick();
    mem_if.i_mem_ack = 1'b0; mem_if.i_mem_rdata = 32'hAAAA_5555;
    check("il_pulse", {31'd0, il}, 32'd1);
    check("instr0", instruction, 32'h8003_0123);
    check("opc0", opc, 32'd0);
    check("req_low_hold", {31'd0, mem_if.o_mem_req}, 32'd0);

    // IR stall: five cycles with i_ir_ready low
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_il", {31'd0, il}, 32'd0);
      check("stall_req", {31'd0, mem_if.o_mem_req}, 32'd0);
      check("stall_instr", instruction, 32'h8003_0123);
    end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("next_req", {31'd0, mem_if.o_mem_req}, 32'd1);
    check("next_addr1", mem_if.o_mem_addr, 32'd1);

    fetch(32'h1000_0001, 32'd1);
    fetch(32'h1000_0002, 32'd2);
    check("addr3", mem_if.o_mem_addr, 32'd3);

    // Redirect during REQ at address 3
    pc_ld = 1'b1; pc_target = 32'h0000_0040;
    tick();
    pc_ld = 1'b0;
    check("redir_addr_stable", mem_if.o_mem_addr, 32'd3);
    mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_if.i_mem_ack = 1'b0;
    check("redir_no_il", {31'd0, il}, 32'd0);
    check("redir_instr_kept", instruction, 32'h1000_0002);
    check("redir_pc_kept", opc, 32'd2);
    check("redir_req", {31'd0, mem_if.o_mem_req}, 32'd1);
    check("redir_addr40", mem_if.o_mem_addr, 32'h40);

    // Redirect in the same cycle as the ack
    pc_ld = 1'b1; pc_target = 32'h80;
    mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 32'hBAD0_0001;
    tick();
    pc_ld = 1'b0; mem_if.i_mem_ack = 1'b0;
    check("samecyc_no_il", {31'd0, il}, 32'd0);
    check("samecyc_addr80", mem_if.o_mem_addr, 32'h80);

    // Second redirect overwrites the first
    pc_ld = 1'b1; pc_target = 32'h100;
    tick();
    pc_target = 32'h200;
    tick();
    pc_ld = 1'b0;
    mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 32'hBAD0_0002;
    tick();
    mem_if.i_mem_ack = 1'b0;
    check("overwrite_no_il", {31'd0, il}, 32'd0);
    check("overwrite_addr200", mem_if.o_mem_addr, 32'h200);

    // PC wrap: load FFFF_FFFF while in HOLD
    mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 32'h0000_0011;
    tick();
    mem_if.i_mem_ack = 1'b0;
    check("w_il", {31'd0, il}, 32'd1);
    check("w_opc200", opc, 32'h200);
    pc_ld = 1'b1; pc_target = 32'hFFFF_FFFF;
    tick();
    pc_ld = 1'b0;
    check("hold_ld_busy", {31'd0, busy}, 32'd1);
    check("hold_ld_noreq", {31'd0, mem_if.o_mem_req}, 32'd0);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("wrap_addr", mem_if.o_mem_addr, 32'hFFFF_FFFF);
    fetch(32'h0000_0022, 32'hFFFF_FFFF);
    check("wrap_next0", mem_if.o_mem_addr, 32'd0);

    // Run dropped mid-REQ: request completes, then IDLE
    run = 1'b0;
    mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 32'h0000_0033;
    tick();
    mem_if.i_mem_ack = 1'b0;
    check("stop_il", {31'd0, il}, 32'd1);
    check("stop_instr", instruction, 32'h0000_0033);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("stop_idle_busy", {31'd0, busy}, 32'd0);
    check("stop_idle_req", {31'd0, mem_if.o_mem_req}, 32'd0);
    mem_if.i_mem_ack = 1'b1;
    tick();
    mem_if.i_mem_ack = 1'b0;
    check("idle_ack_il", {31'd0, il}, 32'd0);
    check("idle_ack_busy", {31'd0, busy}, 32'd0);

    // No ack: watchdog (if built) or indefinite wait
    run = 1'b1;
    tick();
    check("to_addr1", mem_if.o_mem_addr, 32'd1);
    for (int i = 0; i < 14; i++) begin
      tick();
      check("to_wait_req", {31'd0, mem_if.o_mem_req}, 32'd1);
      check("to_wait_fault", {31'd0, fault}, 32'd0);
    end
    tick();
`ifdef IFETCH_TIMEOUT_EN
    check("to_fault", {31'd0, fault}, 32'd1);
    check("to_req_drop", {31'd0, mem_if.o_mem_req}, 32'd0);
    tick();
    check("to_reissue_req", {31'd0, mem_if.o_mem_req}, 32'd1);
    check("to_reissue_addr", mem_if.o_mem_addr, 32'd1);
    check("to_fault_sticky", {31'd0, fault}, 32'd1);
`else
    for (int i = 0; i < 10; i++) begin
      check("nto_req", {31'd0, mem_if.o_mem_req}, 32'd1);
      check("nto_fault", {31'd0, fault}, 32'd0);
      tick();
    end
    check("nto_addr", mem_if.o_mem_addr, 32'd1);
`endif

    // Reset mid-REQ, then a stale ack
    rstn = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, mem_if.o_mem_req}, 32'd0);
    check("mid_rst_addr", mem_if.o_mem_addr, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_fault", {31'd0, fault}, 32'd0);
    run = 1'b0;
    tick();
    rstn = 1'b1;
    mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 32'hBAD0_0003;
    tick();
    mem_if.i_mem_ack = 1'b0;
    check("stale_il", {31'd0, il}, 32'd0);
    check("stale_instr", instruction, 32'd0);
    run = 1'b1;
    tick();
    check("restart_req", {31'd0, mem_if.o_mem_req}, 32'd1);
    check("restart_addr", mem_if.o_mem_addr, 32'd0);
    fetch(32'h0000_0044, 32'd0);
    check("restart_next", mem_if.o_mem_addr, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
